// File: rtl/jb_power_up_seq_if.sv
// Control and status bundle between the AXI register block and the
// power-up sequencer.
interface jb_power_up_seq_if;
    logic       psu_shutdown;
    logic       restart_req;
    logic       stop_req;
    logic       auto_restart_en;
    logic       fault_clr;
    logic       psu_enable;
    logic       dac_enable;
    logic       pa_enable;
    logic       seq_done;
    logic [2:0] seq_state;
    logic [7:0] fault_cnt;

    modport master (
        output psu_shutdown, restart_req, stop_req, auto_restart_en, fault_clr,
        input  psu_enable, dac_enable, pa_enable, seq_done, seq_state, fault_cnt
    );

    modport slave (
        input  psu_shutdown, restart_req, stop_req, auto_restart_en, fault_clr,
        output psu_enable, dac_enable, pa_enable, seq_done, seq_state, fault_cnt
    );
endinterface

// File: rtl/jb_power_up_seq.sv
// Power-up / recovery sequencer: qualifies a clear psu_shutdown, then brings up
// PSU, DAC and PA in order; any shutdown during ramp/run drops everything.
module jb_power_up_seq #(
    parameter int unsigned QUAL_CYC = 1000,
    parameter int unsigned PSU_DLY  = 10000,
    parameter int unsigned DAC_DLY  = 1000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic              axi_clk,
    input  logic              axi_resetn,
    jb_power_up_seq_if.slave  bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_QUALIFY  = 3'd1;
    localparam logic [2:0] ST_PSU_RAMP = 3'd2;
    localparam logic [2:0] ST_DAC_RAMP = 3'd3;
    localparam logic [2:0] ST_RUN      = 3'd4;

    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(QUAL_CYC - 1);
    localparam logic [CNT_W-1:0] PSU_LAST  = CNT_W'(PSU_DLY - 1);
    localparam logic [CNT_W-1:0] DAC_LAST  = CNT_W'(DAC_DLY - 1);

    logic [1:0]       sd_ff;
    logic             sd_sync;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             abort;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       fault_cnt;

    // Reset to 1 so the chain reads "shut down" until the real level arrives.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) sd_ff <= 2'b11;
        else             sd_ff <= {sd_ff[0], bus.psu_shutdown};
    end
    assign sd_sync = sd_ff[1];

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        if (bus.stop_req) begin
            state_nxt = ST_IDLE;
        end else if (sd_sync && (state == ST_PSU_RAMP || state == ST_DAC_RAMP ||
                                 state == ST_RUN)) begin
            state_nxt = ST_IDLE;
            abort     = 1'b1;
        end else begin
            case (state)
                ST_IDLE:     if (bus.restart_req || bus.auto_restart_en) state_nxt = ST_QUALIFY;
                ST_QUALIFY:  if (!sd_sync && cnt == QUAL_LAST) state_nxt = ST_PSU_RAMP;
                ST_PSU_RAMP: if (cnt == PSU_LAST) state_nxt = ST_DAC_RAMP;
                ST_DAC_RAMP: if (cnt == DAC_LAST) state_nxt = ST_RUN;
                ST_RUN:      state_nxt = ST_RUN;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    // One dwell counter shared by all timed states; any state change restarts it.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn)
            cnt <= '0;
        else if (state_nxt != state)
            cnt <= '0;
        else if (state == ST_QUALIFY && sd_sync)
            cnt <= '0;
        else if (state == ST_QUALIFY || state == ST_PSU_RAMP || state == ST_DAC_RAMP)
            cnt <= cnt + CNT_W'(1);
        else
            cnt <= '0;
    end

    // A clear coinciding with an abort keeps that abort in the count.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn)
            fault_cnt <= 8'd0;
        else if (bus.fault_clr)
            fault_cnt <= {7'd0, abort};
        else if (abort && fault_cnt != 8'hff)
            fault_cnt <= fault_cnt + 8'd1;
    end

    assign bus.psu_enable = (state == ST_PSU_RAMP) || (state == ST_DAC_RAMP) || (state == ST_RUN);
    assign bus.dac_enable = (state == ST_DAC_RAMP) || (state == ST_RUN);
    assign bus.pa_enable  = (state == ST_RUN);
    assign bus.seq_done   = (state == ST_RUN);
    assign bus.seq_state  = state;
    assign bus.fault_cnt  = fault_cnt;

endmodule

// File: tb/tb_jb_power_up_seq.sv
// Self-checking bench for jb_power_up_seq against a cycle-count reference model.
module tb_jb_power_up_seq;
    localparam int QC = 4;
    localparam int PD = 8;
    localparam int DD = 3;

    logic axi_clk = 1'b0;
    logic axi_resetn;

    jb_power_up_seq_if ifc();

    jb_power_up_seq #(.QUAL_CYC(QC), .PSU_DLY(PD), .DAC_DLY(DD), .CNT_W(24)) dut (
        .axi_clk    (axi_clk),
        .axi_resetn (axi_resetn),
        .bus        (ifc.slave)
    );

    always #5 axi_clk = ~axi_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase number, cycles spent in phase, consecutive clear
    // cycles while qualifying, abort count and the two-stage sync delay line.
    int m_ph, m_el, m_run, m_faults;
    bit m_s1, m_s2;

    task automatic model_reset();
        m_ph = 0; m_el = 0; m_run = 0; m_faults = 0; m_s1 = 1'b1; m_s2 = 1'b1;
    endtask

    task automatic model_update();
        bit sd, fault;
        int nph;
        sd = m_s2; fault = 1'b0; nph = m_ph;
        if (ifc.stop_req) nph = 0;
        else if (sd && m_ph >= 2 && m_ph <= 4) begin nph = 0; fault = 1'b1; end
        else begin
            case (m_ph)
                0: if (ifc.restart_req || ifc.auto_restart_en) nph = 1;
                1: if (sd) m_run = 0;
                   else begin m_run++; if (m_run == QC) nph = 2; end
                2: begin m_el++; if (m_el == PD) nph = 3; end
                3: begin m_el++; if (m_el == DD) nph = 4; end
                default: ;
            endcase
        end
        if (nph != m_ph) begin m_el = 0; m_run = 0; end
        if (ifc.fault_clr) m_faults = fault ? 1 : 0;
        else if (fault && m_faults < 255) m_faults++;
        m_ph = nph;
        m_s2 = m_s1;
        m_s1 = ifc.psu_shutdown;
    endtask

    function automatic logic [14:0] exp_vec();
        return {m_ph >= 2, m_ph >= 3, m_ph == 4, m_ph == 4, 3'(m_ph), 8'(m_faults)};
    endfunction

    function automatic logic [14:0] obs();
        return {ifc.psu_enable, ifc.dac_enable, ifc.pa_enable, ifc.seq_done,
                ifc.seq_state, ifc.fault_cnt};
    endfunction

    // Inputs change on the falling edge; the model advances with the rising edge.
    task automatic step();
        @(posedge axi_clk);
        model_update();
        @(negedge axi_clk);
    endtask

    task automatic test_reset();
        ifc.psu_shutdown = 1'b0; ifc.restart_req = 1'b0; ifc.stop_req = 1'b0;
        ifc.auto_restart_en = 1'b0; ifc.fault_clr = 1'b0;
        axi_resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs() !== 15'd0) begin
            errors++; $display("FAIL reset_async got %h exp %h", obs(), 15'd0);
        end
        @(negedge axi_clk); @(negedge axi_clk);
        axi_resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL reset_idle%0d got %h exp %h", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_sequence();
        int n;
        ifc.restart_req = 1'b1;
        step();
        ifc.restart_req = 1'b0;
        checks++;
        if (ifc.seq_state !== 3'd1) begin
            errors++; $display("FAIL seq_enter_qualify got %0d exp 1", ifc.seq_state);
        end
        n = 0;
        while (ifc.psu_enable !== 1'b1 && n < 50) begin
            step(); n++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL seq_psu_cyc%0d got %h exp %h", n, obs(), exp_vec());
            end
        end
        checks++;
        if (n !== QC || ifc.seq_state !== 3'd2) begin
            errors++; $display("FAIL seq_psu_rise got %0d cyc st %0d exp %0d cyc st 2", n, ifc.seq_state, QC);
        end
        n = 0;
        while (ifc.dac_enable !== 1'b1 && n < 50) begin
            step(); n++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL seq_dac_cyc%0d got %h exp %h", n, obs(), exp_vec());
            end
        end
        checks++;
        if (n !== PD || ifc.seq_state !== 3'd3) begin
            errors++; $display("FAIL seq_dac_rise got %0d cyc st %0d exp %0d cyc st 3", n, ifc.seq_state, PD);
        end
        n = 0;
        while (ifc.pa_enable !== 1'b1 && n < 50) begin
            step(); n++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL seq_pa_cyc%0d got %h exp %h", n, obs(), exp_vec());
            end
        end
        checks++;
        if (n !== DD || ifc.seq_done !== 1'b1 || ifc.seq_state !== 3'd4 || ifc.fault_cnt !== 8'd0) begin
            errors++; $display("FAIL seq_pa_rise got %0d cyc done %b fc %0d exp %0d cyc done 1 fc 0",
                               n, ifc.seq_done, ifc.fault_cnt, DD);
        end
    endtask

    task automatic test_abort();
        int n;
        ifc.psu_shutdown = 1'b1;
        n = 0;
        while (ifc.psu_enable !== 1'b0 && n < 10) begin
            step(); n++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL abort_cyc%0d got %h exp %h", n, obs(), exp_vec());
            end
        end
        checks++;
        if (n !== 3 || obs() !== {4'b0000, 3'd0, 8'd1}) begin
            errors++; $display("FAIL abort_latency got %0d cyc out %h exp 3 cyc out %h", n, obs(), {4'b0000, 3'd0, 8'd1});
        end
        ifc.psu_shutdown = 1'b0;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_qualify_glitch();
        int n;
        ifc.restart_req = 1'b1; step(); ifc.restart_req = 1'b0;
        step();
        ifc.psu_shutdown = 1'b1;
        step(); step();
        ifc.psu_shutdown = 1'b0;
        n = 0;
        while (ifc.psu_enable !== 1'b1 && n < 50) begin
            step(); n++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL qual_cyc%0d got %h exp %h", n, obs(), exp_vec());
            end
        end
        checks++;
        if (n !== QC + 2 || ifc.fault_cnt !== 8'd1) begin
            errors++; $display("FAIL qual_restart got %0d cyc fc %0d exp %0d cyc fc 1", n, ifc.fault_cnt, QC + 2);
        end
        ifc.stop_req = 1'b1; step(); ifc.stop_req = 1'b0;
    endtask

    task automatic test_saturate();
        int n;
        for (int a = 0; a < 300; a++) begin
            ifc.restart_req = 1'b1; step(); ifc.restart_req = 1'b0;
            n = 0;
            while (ifc.psu_enable !== 1'b1 && n < 20) begin step(); n++; end
            if (n >= 20) begin
                checks++; errors++; $display("FAIL sat_timeout iter %0d", a);
            end
            repeat ($urandom_range(0, 3)) step();
            ifc.psu_shutdown = 1'b1;
            step(); step(); step();
            ifc.psu_shutdown = 1'b0;
            step(); step();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL sat_iter%0d got %h exp %h", a, obs(), exp_vec());
            end
        end
        checks++;
        if (ifc.fault_cnt !== 8'd255) begin
            errors++; $display("FAIL sat_hold got %0d exp 255", ifc.fault_cnt);
        end
    endtask

    task automatic test_stop_vs_shutdown();
        int n;
        logic [7:0] fc0;
        fc0 = ifc.fault_cnt;
        ifc.restart_req = 1'b1; step(); ifc.restart_req = 1'b0;
        n = 0;
        while (ifc.dac_enable !== 1'b1 && n < 50) begin step(); n++; end
        ifc.stop_req = 1'b1; ifc.psu_shutdown = 1'b1;
        step();
        ifc.stop_req = 1'b0;
        checks++;
        if (obs() !== {7'd0, fc0} || n >= 50) begin
            errors++; $display("FAIL stop_sd got %h exp %h", obs(), {7'd0, fc0});
        end
        ifc.psu_shutdown = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs() !== exp_vec() || ifc.fault_cnt !== fc0) begin
                errors++; $display("FAIL stop_after%0d got %h exp %h", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_auto_restart();
        int n;
        ifc.auto_restart_en = 1'b1;
        n = 0;
        while (ifc.seq_done !== 1'b1 && n < 60) begin step(); n++; end
        checks++;
        if (n >= 60) begin errors++; $display("FAIL auto_first got done %b exp 1", ifc.seq_done); end
        ifc.psu_shutdown = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL auto_sd%0d got %h exp %h", i, obs(), exp_vec());
            end
        end
        ifc.psu_shutdown = 1'b0;
        n = 0;
        while (ifc.seq_done !== 1'b1 && n < 60) begin
            step(); n++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL auto_reseq%0d got %h exp %h", n, obs(), exp_vec());
            end
        end
        checks++;
        if (n >= 60) begin errors++; $display("FAIL auto_rerun got done %b exp 1", ifc.seq_done); end
        ifc.psu_shutdown = 1'b1;
        step(); step();
        ifc.fault_clr = 1'b1;
        step();
        ifc.fault_clr = 1'b0; ifc.auto_restart_en = 1'b0; ifc.psu_shutdown = 1'b0;
        checks++;
        if (ifc.fault_cnt !== 8'd1 || ifc.psu_enable !== 1'b0) begin
            errors++; $display("FAIL clr_with_abort got fc %0d psu %b exp fc 1 psu 0", ifc.fault_cnt, ifc.psu_enable);
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 29) == 0) ifc.psu_shutdown = ~ifc.psu_shutdown;
            ifc.restart_req = ($urandom_range(0, 9) == 0);
            ifc.stop_req    = ($urandom_range(0, 99) == 0);
            ifc.fault_clr   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 199) == 0) ifc.auto_restart_en = ~ifc.auto_restart_en;
            step();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL rand%0d got %h exp %h", i, obs(), exp_vec());
            end
        end
        ifc.psu_shutdown = 1'b0; ifc.restart_req = 1'b0; ifc.stop_req = 1'b1;
        ifc.fault_clr = 1'b0; ifc.auto_restart_en = 1'b0;
        step();
        ifc.stop_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_async_reset();
        int n;
        ifc.restart_req = 1'b1; step(); ifc.restart_req = 1'b0;
        n = 0;
        while (ifc.psu_enable !== 1'b1 && n < 50) begin step(); n++; end
        step(); step();
        checks++;
        if (ifc.seq_state !== 3'd2) begin
            errors++; $display("FAIL arst_pre got st %0d exp 2", ifc.seq_state);
        end
        #2 axi_resetn = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs() !== 15'd0) begin
            errors++; $display("FAIL arst_immediate got %h exp %h", obs(), 15'd0);
        end
        @(negedge axi_clk);
        axi_resetn = 1'b1;
        step();
        checks++;
        if (obs() !== exp_vec() || ifc.seq_state !== 3'd0) begin
            errors++; $display("FAIL arst_release got %h exp %h", obs(), exp_vec());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequence();
        test_abort();
        test_qualify_glitch();
        test_saturate();
        test_stop_vs_shutdown();
        test_auto_restart();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
